// File: rtl/tinyrisc_pkg.sv
// tinyRisc shared definitions: fetch widths, reset PC, fetch FSM encodings and
// a saturating increment helper used by the optional performance counters.
package tinyrisc_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  // Increment a 32-bit event counter, sticking at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Two saturating 32-bit event counters for the fetch sequencer: accepted fetch
// requests and stall cycles. Cleared by the synchronous reset.
module fetch_perf_counters
  import tinyrisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  // Count events, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (fetch_inc) begin
        fetch_cnt <= sat_inc32(fetch_cnt);
      end
      if (stall_inc) begin
        stall_cnt <= sat_inc32(stall_cnt);
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// tinyRisc fetch sequencer: owns the PC, issues one-outstanding word reads to
// instruction memory and hands fetched instructions to decode. Redirects from
// the PC-update logic retarget fetch and kill any in-flight response.
// Optional macro FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_sequencer
  import tinyrisc_pkg::*;
#(
  parameter int                PC_W     = tinyrisc_pkg::PC_W,
  parameter int                INSTR_W  = tinyrisc_pkg::INSTR_W,
  parameter logic [PC_W-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  output logic               busy
);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic [PC_W-1:0] fetch_pc, fetch_pc_n;
  logic            kill, kill_n;
  logic            latch_rsp;
  logic            req_hs;

  // Next-state, next-PC and kill decisions; redirect outranks everything but reset.
  always_comb begin
    state_n    = state;
    pc_n       = pc_q;
    fetch_pc_n = fetch_pc;
    kill_n     = kill;
    latch_rsp  = 1'b0;
    req_hs     = imem_req_valid & imem_req_ready;
    case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
        end else if (halt) begin
          state_n = S_HALT;
        end else begin
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        if (req_hs) begin
          fetch_pc_n = pc_q;
          state_n    = S_WAIT;
          if (redirect_valid) begin
            pc_n   = redirect_pc;
            kill_n = 1'b1;
          end else begin
            pc_n = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end else if (redirect_valid) begin
          pc_n = redirect_pc;
        end else if (halt) begin
          state_n = S_HALT;
        end else begin
          state_n = S_FETCH;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (imem_rsp_valid) begin
            kill_n  = 1'b0;
            state_n = S_FETCH;
          end else begin
            kill_n = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = S_FETCH;
          end else begin
            latch_rsp = 1'b1;
            state_n   = S_HOLD;
          end
        end else begin
          state_n = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = S_FETCH;
        end else if (instr_ready) begin
          state_n = halt ? S_HALT : S_FETCH;
        end else begin
          state_n = S_HOLD;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
        end else if (!halt) begin
          state_n = S_FETCH;
        end else begin
          state_n = S_HALT;
        end
      end
      default: begin
        state_n = S_IDLE;
        kill_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      pc_q           <= RESET_PC;
      fetch_pc       <= {PC_W{1'b0}};
      kill           <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= {PC_W{1'b0}};
      instr_valid    <= 1'b0;
      instr_out      <= {INSTR_W{1'b0}};
      instr_pc       <= {PC_W{1'b0}};
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      pc_q           <= pc_n;
      fetch_pc       <= fetch_pc_n;
      kill           <= kill_n;
      imem_req_valid <= (state_n == S_FETCH);
      if (state_n == S_FETCH) begin
        imem_req_addr <= pc_n;
      end
      instr_valid    <= (state_n == S_HOLD);
      if (latch_rsp) begin
        instr_out <= imem_rsp_data;
        instr_pc  <= fetch_pc;
      end
      busy           <= (state_n == S_WAIT) | (state_n == S_FETCH);
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_event;
  assign stall_event = ((state == S_HOLD) & ~instr_ready) |
                       ((state == S_FETCH) & ~imem_req_ready);

  fetch_perf_counters u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (req_hs),
    .stall_inc (stall_event),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer. A memory model answers
// requests after a random delay; the reference tracks the architectural PC
// and the stream of instructions decode should see, honouring redirects.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   deliveries  = 0;

  function automatic logic [31:0] instr_of(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each instruction decode consumes; drops a held one on redirect.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && instr_valid && (instr_ready || redirect_valid)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr", 64'(instr_pc), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          if (instr_ready) begin
            check("instr_pc", 64'(instr_pc), 64'(e.pc));
            check("instr_out", 64'(instr_out), 64'(e.ins));
            deliveries++;
          end
        end
      end
    end
  end

  // Stimulus, memory model and PC reference.
  initial begin
    logic [15:0] model_pc;
    logic [15:0] mem_addr;
    logic        mem_pending;
    logic        mem_kill;
    int          mem_delay;
    logic        dut_out;
    logic        halt_chk;
    logic        new_rst;
    logic        rv;
    logic [15:0] ra;
    logic        firing;
    int          since_rst;
    int unsigned fcnt;
    int unsigned scnt;

    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'd0; halt = 1'b0;
    model_pc = 16'h0000; mem_addr = 16'd0; mem_pending = 1'b0; mem_kill = 1'b0;
    mem_delay = 0; dut_out = 1'b0; halt_chk = 1'b0; since_rst = 0; fcnt = 0; scnt = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr_out", 64'(instr_out), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rv = imem_req_valid;
      ra = imem_req_addr;
      if (halt_chk) begin
        check("halt_stops_req", 64'(imem_req_valid), 64'd0);
      end
      halt_chk = 1'b0;
      check("busy", 64'(busy), 64'(dut_out | rv));
`ifdef FETCH_PERF_EN
      check("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(fcnt));
      check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(scnt));
`endif

      new_rst = (cyc >= 2000 && cyc < 2002);

      // Memory side: one outstanding request, not ready while busy.
      imem_req_ready = ($urandom_range(0, 3) != 0) && !mem_pending;
      firing = mem_pending && (mem_delay == 0);
      if (firing) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mem_addr);
      end else if (!mem_pending && $urandom_range(0, 15) == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
      end

      // Core side.
      redirect_valid = !new_rst && (since_rst >= 2) && ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 16'hFFFF;
        1:       redirect_pc = 16'h0040;
        2:       redirect_pc = 16'h0080;
        default: redirect_pc = 16'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) begin
        halt = ~halt;
      end
      instr_ready = ($urandom_range(0, 3) != 0);
      rst = new_rst;

      // Reference update for the coming clock edge.
      if (firing) begin
        if (!mem_kill && !redirect_valid && !new_rst) begin
          exp_q.push_back('{pc: mem_addr, ins: instr_of(mem_addr)});
        end
        mem_pending = 1'b0;
        dut_out     = 1'b0;
      end else if (mem_pending) begin
        mem_delay--;
        if (redirect_valid) begin
          mem_kill = 1'b1;
        end
      end

      if (new_rst) begin
        exp_q.delete();
        dut_out   = 1'b0;
        mem_kill  = 1'b1;
        model_pc  = 16'h0000;
        since_rst = 0;
        fcnt      = 0;
        scnt      = 0;
      end else begin
        if ((rv && !imem_req_ready) || (instr_valid && !instr_ready)) begin
          scnt++;
        end
        if (rv && imem_req_ready) begin
          check("req_addr", 64'(ra), 64'(model_pc));
          fcnt++;
          model_pc    = ra + 16'd1;
          mem_addr    = ra;
          mem_pending = 1'b1;
          mem_kill    = redirect_valid;
          mem_delay   = $urandom_range(0, 2);
          dut_out     = 1'b1;
        end
        if (redirect_valid) begin
          model_pc = redirect_pc;
        end
        halt_chk = halt && rv && !imem_req_ready && !redirect_valid;
        since_rst++;
      end

      @(negedge clk);
    end

    check("min_deliveries", 64'(deliveries >= 100), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
